// File: rtl/vga_shapes_pkg.sv
// Shared types and constants for the multi-sprite VGA shape bouncer: colour
// type, sprite palette, default sprite size and the load-time position clamp.
package vga_shapes_pkg;

    localparam int COLOR_W = 4;

    typedef logic [3*COLOR_W-1:0] rgb_t;

    localparam rgb_t PALETTE [8] = '{
        12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
        12'h0FF, 12'hF0F, 12'hFFF, 12'hF80
    };

    localparam logic [9:0] SIZE_RST = 10'd60;

    // Keep a sprite fully inside [0, limit): top-left may not exceed limit-size.
    function automatic logic [9:0] clamp_pos(input logic [9:0]  pos,
                                             input logic [10:0] limit,
                                             input logic [9:0]  sz);
        logic [10:0] top;
        top = ({1'b0, sz} > limit) ? 11'd0 : limit - {1'b0, sz};
        return ({1'b0, pos} > top) ? top[9:0] : pos;
    endfunction

endpackage

// File: rtl/vga_shape_mover.sv
// Position state for one sprite: reset placement, clamped load and, when
// VGA_SHAPES_MOTION_EN is defined, the per-frame bounce movement.
module vga_shape_mover
    import vga_shapes_pkg::*;
#(
    parameter int         WIDTH  = 640,
    parameter int         HEIGHT = 480,
    parameter int         STEP   = 2,
    parameter logic [9:0] X_RST  = 10'd0,
    parameter logic [9:0] Y_RST  = 10'd0,
    parameter logic       DY_RST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
`ifdef VGA_SHAPES_MOTION_EN
    input  logic       tick,
    input  logic [9:0] size,
`endif
    input  logic [9:0] x_load,
    input  logic [9:0] y_load,
    input  logic [9:0] size_load,
    output logic [9:0] x,
    output logic [9:0] y
);

    logic [9:0] x_load_clamped;
    logic [9:0] y_load_clamped;

    assign x_load_clamped = clamp_pos(x_load, 11'(WIDTH), size_load);
    assign y_load_clamped = clamp_pos(y_load, 11'(HEIGHT), size_load);

`ifdef VGA_SHAPES_MOTION_EN
    logic        dx;
    logic        dy;
    logic [10:0] x_step;
    logic [10:0] y_step;

    // Returns {dir, pos}; all arithmetic at 11 bits so edge tests never wrap.
    function automatic logic [10:0] bounce(input logic [9:0]  pos,
                                           input logic        dir,
                                           input logic [9:0]  sz,
                                           input logic [10:0] limit);
        logic [10:0] p;
        logic [10:0] s;
        logic [10:0] st;
        logic [10:0] edge_pos;
        p        = {1'b0, pos};
        s        = {1'b0, sz};
        st       = 11'(STEP);
        edge_pos = limit - s;
        if (dir && (p + s + st > limit))
            return {1'b0, edge_pos[9:0]};
        else if (!dir && (p < st))
            return {1'b1, 10'd0};
        else if (dir)
            return {1'b1, 10'(p + st)};
        else
            return {1'b0, 10'(p - st)};
    endfunction

    assign x_step = bounce(x, dx, size, 11'(WIDTH));
    assign y_step = bounce(y, dy, size, 11'(HEIGHT));

    // A load in the tick cycle takes priority, so that frame does not move.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x  <= X_RST;
            y  <= Y_RST;
            dx <= 1'b1;
            dy <= DY_RST;
        end else if (load) begin
            x  <= x_load_clamped;
            y  <= y_load_clamped;
            dx <= 1'b1;
            dy <= 1'b1;
        end else if (tick) begin
            {dx, x} <= x_step;
            {dy, y} <= y_step;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= X_RST;
            y <= Y_RST;
        end else if (load) begin
            x <= x_load_clamped;
            y <= y_load_clamped;
        end
    end
`endif

endmodule

// File: rtl/vga_shape_bouncer.sv
// Renders N_SHAPES filled squares over a background with fixed priority and
// re-times sync by one cycle. Motion is enabled by VGA_SHAPES_MOTION_EN.
module vga_shape_bouncer
    import vga_shapes_pkg::*;
#(
    parameter int   WIDTH    = 640,
    parameter int   H_FP     = 16,
    parameter int   H_PW     = 96,
    parameter int   H_BP     = 48,
    parameter int   HEIGHT   = 480,
    parameter int   V_FP     = 10,
    parameter int   V_PW     = 2,
    parameter int   V_BP     = 33,
    parameter int   N_SHAPES = 4,
    parameter int   STEP     = 2,
    parameter rgb_t BG_RGB   = 12'h000
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic [9:0]              iCountH,
    input  logic [9:0]              iCountV,
    input  logic                    iHS,
    input  logic                    iVS,
    input  logic                    iLoad,
    input  logic [10*N_SHAPES-1:0]  iShapeX,
    input  logic [10*N_SHAPES-1:0]  iShapeY,
    input  logic [9:0]              iShapeSize,
    output logic [COLOR_W-1:0]      oRed,
    output logic [COLOR_W-1:0]      oGreen,
    output logic [COLOR_W-1:0]      oBlue,
    output logic                    oHS,
    output logic                    oVS
);

    // The 10-bit counters from the timing generator must cover a whole line/frame.
    if ((WIDTH + H_FP + H_PW + H_BP > 1024) || (HEIGHT + V_FP + V_PW + V_BP > 1024) ||
        (N_SHAPES < 1) || (N_SHAPES > 8) || (STEP < 1) || (STEP > 15)) begin : gen_bad_cfg
        $error("vga_shape_bouncer: unsupported parameter set");
    end

    logic [10:0] h11;
    logic [10:0] v11;
    logic [9:0]  size;
    logic [9:0]  size_load;
    logic [9:0]  pos_x [N_SHAPES];
    logic [9:0]  pos_y [N_SHAPES];
    logic [N_SHAPES-1:0] hit;
    rgb_t        chain [N_SHAPES+1];
    rgb_t        rgb_next;
    logic        active;

    assign h11       = {1'b0, iCountH};
    assign v11       = {1'b0, iCountV};
    assign size_load = ({1'b0, iShapeSize} > 11'(HEIGHT)) ? 10'(HEIGHT) : iShapeSize;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst)
            size <= SIZE_RST;
        else if (iLoad)
            size <= size_load;
    end

`ifdef VGA_SHAPES_MOTION_EN
    logic tick;
    // First blanking line, column 0: outside the active area, so moves never tear.
    assign tick = (iCountH == 10'd0) && (v11 == 11'(HEIGHT));
`endif

    assign chain[N_SHAPES] = BG_RGB;

    for (genvar g = 0; g < N_SHAPES; g++) begin : gen_shape
        vga_shape_mover #(
            .WIDTH  (WIDTH),
            .HEIGHT (HEIGHT),
            .STEP   (STEP),
            .X_RST  (10'((g * WIDTH) / N_SHAPES)),
            .Y_RST  (10'((g * HEIGHT) / N_SHAPES)),
            .DY_RST ((g % 2) == 0)
        ) u_mover (
            .clk       (iClk),
            .rst       (iRst),
            .load      (iLoad),
`ifdef VGA_SHAPES_MOTION_EN
            .tick      (tick),
            .size      (size),
`endif
            .x_load    (iShapeX[10*g +: 10]),
            .y_load    (iShapeY[10*g +: 10]),
            .size_load (size_load),
            .x         (pos_x[g]),
            .y         (pos_y[g])
        );

        assign hit[g] = ({1'b0, pos_x[g]} <= h11) && (h11 < {1'b0, pos_x[g]} + {1'b0, size}) &&
                        ({1'b0, pos_y[g]} <= v11) && (v11 < {1'b0, pos_y[g]} + {1'b0, size});

        // Lower index wins: each stage overrides everything behind it.
        assign chain[g] = hit[g] ? PALETTE[g] : chain[g+1];
    end

    assign active = (h11 < 11'(WIDTH)) && (v11 < 11'(HEIGHT));

    always_comb begin
        rgb_next = '0;
        if (active)
            rgb_next = chain[0];
    end

    // Output stage: colour and sync share the same single register delay.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oRed   <= '0;
            oGreen <= '0;
            oBlue  <= '0;
            oHS    <= 1'b1;
            oVS    <= 1'b1;
        end else begin
            oRed   <= rgb_next[3*COLOR_W-1 -: COLOR_W];
            oGreen <= rgb_next[2*COLOR_W-1 -: COLOR_W];
            oBlue  <= rgb_next[COLOR_W-1:0];
            oHS    <= iHS;
            oVS    <= iVS;
        end
    end

endmodule

// File: tb/tb_vga_shape_bouncer.sv
// Directed bench for vga_shape_bouncer: counters are driven directly and each
// expected {rgb, hs, vs} is queued at drive time and checked one cycle later.
module tb_vga_shape_bouncer;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  count_h, count_v;
    logic        hs, vs, load;
    logic [39:0] shape_x, shape_y;
    logic [9:0]  shape_size;
    logic [3:0]  red, green, blue;
    logic        hs_out, vs_out;

    always #5 clk = ~clk;

    vga_shape_bouncer dut (
        .iClk       (clk),
        .iRst       (rst),
        .iCountH    (count_h),
        .iCountV    (count_v),
        .iHS        (hs),
        .iVS        (vs),
        .iLoad      (load),
        .iShapeX    (shape_x),
        .iShapeY    (shape_y),
        .iShapeSize (shape_size),
        .oRed       (red),
        .oGreen     (green),
        .oBlue      (blue),
        .oHS        (hs_out),
        .oVS        (vs_out)
    );

    int total = 0;
    int bad   = 0;
    logic [13:0] exp_q [$];
    string       tag_q [$];
    int mx [4];
    int my [4];
    int msz;
    logic [11:0] pal [4];

    function automatic logic [11:0] model_rgb(input int h, input int v);
        if (h < 0 || v < 0 || h >= 640 || v >= 480) return 12'h000;
        for (int i = 0; i < 4; i++)
            if (h >= mx[i] && h < mx[i] + msz && v >= my[i] && v < my[i] + msz)
                return pal[i];
        return 12'h000;
    endfunction

    task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step(input int h, input int v, input logic s_h, input logic s_v, input string tag);
        logic [13:0] e;
        count_h = 10'(h);
        count_v = 10'(v);
        hs = s_h;
        vs = s_v;
        exp_q.push_back({model_rgb(h, v), s_h, s_v});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk(tag_q.pop_front(), {red, green, blue, hs_out, vs_out}, e);
    endtask

    task automatic probe(input int x, input int y, input string tag);
        step(x, y, 1'b0, 1'b1, {tag, "_in"});
        step(x - 1, y, 1'b1, 1'b0, {tag, "_left"});
        step(x, y - 1, 1'b1, 1'b1, {tag, "_above"});
        step(x + msz - 1, y + msz - 1, 1'b0, 1'b0, {tag, "_corner"});
        step(x + msz, y, 1'b1, 1'b1, {tag, "_right"});
    endtask

    task automatic tick(input string tag);
        step(0, 480, 1'b1, 1'b1, tag);
    endtask

    // Shape 0 at (x0,y0); shapes 1..3 at (xr,yr); load pulses at counter (h,v).
    task automatic load_all(input int x0, input int y0, input int xr, input int yr,
                            input int sz, input int h, input int v, input string tag);
        int lx, ly;
        for (int i = 0; i < 4; i++) begin
            shape_x[10*i +: 10] = 10'((i == 0) ? x0 : xr);
            shape_y[10*i +: 10] = 10'((i == 0) ? y0 : yr);
        end
        shape_size = 10'(sz);
        load = 1'b1;
        step(h, v, 1'b1, 1'b1, tag);
        load = 1'b0;
        msz = (sz > 480) ? 480 : sz;
        for (int i = 0; i < 4; i++) begin
            lx = (i == 0) ? x0 : xr;
            ly = (i == 0) ? y0 : yr;
            mx[i] = (lx > 640 - msz) ? 640 - msz : lx;
            my[i] = (ly > 480 - msz) ? 480 - msz : ly;
        end
    endtask

    task automatic model_reset();
        mx  = '{0, 160, 320, 480};
        my  = '{0, 120, 240, 360};
        msz = 60;
    endtask

    initial begin
        pal = '{12'hF00, 12'h0F0, 12'h00F, 12'hFF0};
        model_reset();
        rst = 1'b1;
        count_h = 10'd0; count_v = 10'd0; hs = 1'b0; vs = 1'b0; load = 1'b0;
        shape_x = '0; shape_y = '0; shape_size = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rgb", {2'b00, red, green, blue}, 14'h0);
        chk("reset_hs", {13'd0, hs_out}, 14'd1);
        chk("reset_vs", {13'd0, vs_out}, 14'd1);
        rst = 1'b0;

        // Default placement after reset
        probe(0, 0, "rst_shape0");
        step(59, 59, 1'b0, 1'b0, "px_59_59");
        step(60, 0, 1'b1, 1'b0, "px_60_0_bg");
        step(160, 120, 1'b1, 1'b1, "shape1_origin");
        step(320, 240, 1'b0, 1'b1, "shape2_origin");
        step(480, 360, 1'b1, 1'b1, "shape3_origin");
        step(650, 10, 1'b0, 1'b1, "hblank");
        step(10, 490, 1'b1, 1'b0, "vblank");

        // Overlap: shape 0 keeps priority over all others
        load_all(100, 100, 100, 100, 60, 700, 10, "load_overlap");
        probe(100, 100, "overlap");

        // Zero size makes shapes invisible
        load_all(0, 0, 0, 0, 0, 700, 10, "load_size0");
        step(0, 0, 1'b1, 1'b1, "size0_invisible");

        // Oversized side clamps to HEIGHT, positions clamp to the edge
        load_all(1000, 1000, 1000, 1000, 600, 700, 10, "load_bigsize");
        step(159, 5, 1'b1, 1'b1, "bigsize_left_bg");
        step(160, 5, 1'b1, 1'b1, "bigsize_in");
        step(639, 479, 1'b1, 1'b1, "bigsize_corner");

        // Position clamp on load
        load_all(700, 0, 0, 300, 60, 700, 10, "load_x700");
        probe(580, 0, "clamp_x580");
`ifndef VGA_SHAPES_MOTION_EN
        repeat (3) tick("tick_static");
        probe(580, 0, "static_after_3frames");
        step(0, 300, 1'b1, 1'b1, "static_shape1");
`endif

        // Load in the tick cycle wins over movement
        load_all(200, 100, 0, 300, 60, 0, 480, "load_on_tick");
        probe(200, 100, "load_on_tick_pos");

`ifdef VGA_SHAPES_MOTION_EN
        // Right-edge bounce
        load_all(578, 0, 0, 300, 60, 700, 10, "load_right");
        tick("tick_r1");
        mx = '{580, 2, 2, 2}; my = '{2, 302, 302, 302};
        probe(580, 2, "right_t1");
        tick("tick_r2");
        mx = '{580, 4, 4, 4}; my = '{4, 304, 304, 304};
        probe(580, 4, "right_t2");
        tick("tick_r3");
        mx = '{578, 6, 6, 6}; my = '{6, 306, 306, 306};
        probe(578, 6, "right_t3");

        // Bottom bounce then top bounce from an odd row
        load_all(300, 421, 300, 421, 59, 700, 10, "load_top");
        tick("tick_b1");
        mx = '{302, 302, 302, 302}; my = '{421, 421, 421, 421};
        probe(302, 421, "bottom_t1");
        for (int t = 2; t <= 211; t++) tick("tick_run");
        mx = '{441, 441, 441, 441}; my = '{1, 1, 1, 1};
        probe(441, 1, "top_t211");
        tick("tick_t212");
        mx = '{439, 439, 439, 439}; my = '{0, 0, 0, 0};
        probe(439, 0, "top_t212");
        tick("tick_t213");
        mx = '{437, 437, 437, 437}; my = '{2, 2, 2, 2};
        probe(437, 2, "top_t213");
`endif

        // Mid-frame asynchronous reset
        count_h = 10'd5; count_v = 10'd5; hs = 1'b0; vs = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midreset_rgb", {2'b00, red, green, blue}, 14'h0);
        chk("midreset_sync", {12'd0, hs_out, vs_out}, 14'd3);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        probe(160, 120, "after_midreset_shape1");
        step(0, 0, 1'b1, 1'b1, "after_midreset_shape0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_shape_bouncer.md
# vga_shape_bouncer

Parametrised successor to the single-rectangle pixel generator. Renders `N_SHAPES` filled square sprites over a background and composites them by fixed priority. Each sprite optionally moves by a fixed step once per frame and bounces off the visible-area edges. It sits between `VGA_timings`, whose `oCountH`/`oCountV`/`oHS`/`oVS` it consumes, and the board RGB pins, and re-times sync so that colour and sync stay aligned.

## Interface
Parameters:
- `WIDTH` 640, `H_FP` 16, `H_PW` 96, `H_BP` 48: horizontal timing, identical meaning to `VGA_timings`.
- `HEIGHT` 480, `V_FP` 10, `V_PW` 2, `V_BP` 33: vertical timing.
- `N_SHAPES` 4: sprite count, 1..8.
- `STEP` 2: pixels moved per frame per axis, 1..15.
- `BG_RGB` 12'h000: background colour, {R,G,B} 4 bits each.

Ports (one clock; reset is asynchronous and active-high):
- `iClk`  in  1  pixel clock.
- `iRst`  in  1  async active-high reset.
- `iCountH`, `iCountV`  in  10 each  pixel counters from `VGA_timings`.
- `iHS`, `iVS`  in  1 each  sync from `VGA_timings`.
- `iLoad`  in  1  one-cycle pulse; loads positions and size.
- `iShapeX`, `iShapeY`  in  10*N_SHAPES each  packed positions; shape i is at bits [10i+9:10i].
- `iShapeSize`  in  10  common side length in pixels.
- `oRed`, `oGreen`, `oBlue`  out  4 each  registered colour.
- `oHS`, `oVS`  out  1 each  sync delayed to match colour.

## Operation
- Per shape i: registers `x_i`, `y_i` (10b), `dx_i`, `dy_i` (1b each; 1 means increasing). One common `size` register (10b).
- Reset values:
  - `x_i` = (i*WIDTH)/N_SHAPES and `y_i` = (i*HEIGHT)/N_SHAPES.
  - `dx_i` = 1. `dy_i` = 1 for even i, 0 for odd i.
  - `size` = 60.
  - All RGB outputs 0. `oHS` = `oVS` = 1 (idle level).
- Load: when `iLoad`=1, sample all positions and `size`, and set all direction bits to 1.
  - A position exceeding `WIDTH-size` is clamped to `WIDTH-size`; a position exceeding `HEIGHT-size` is clamped to `HEIGHT-size`.
  - A `size` greater than `HEIGHT` is clamped to `HEIGHT`.
- Frame tick: one cycle where `iCountH`==0 and `iCountV`==HEIGHT, i.e. the first blanking line.
  - Positions change only on the tick or on a load, never inside the active area.
- Bounce rule on the tick, X axis (Y is identical using HEIGHT):
  - If `dx`=1 and `x+size+STEP > WIDTH`: set `x`=WIDTH-size and `dx`=0.
  - Else if `dx`=0 and `x < STEP`: set `x`=0 and `dx`=1.
  - Else: `x` ± STEP.
  - All sums are computed at 11 bits, with no wrap-around.
- Hit test: `hit_i` = (x_i ≤ H < x_i+size) && (y_i ≤ V < y_i+size), evaluated at 11 bits.
  - `size`=0 makes the shape invisible.
- Colour selection:
  - Active area (H<WIDTH and V<HEIGHT): the lowest-index hit shape's palette colour, otherwise `BG_RGB`.
  - Blanking: 0.
- If `iLoad` and the tick occur in the same cycle, the load wins and no movement is applied that frame.
- A reset mid-frame returns all registers to their reset values immediately. The output resynchronises on the next valid counter values; there is no recovery state.

## Timing
- Latency is 1 cycle from `iCountH`/`iCountV`/`iHS`/`iVS` to `oRed`/`oGreen`/`oBlue`/`oHS`/`oVS`, and all outputs are registered.
- A position update is visible from the first active pixel of the next frame.
- A load takes effect on the cycle after `iLoad`.

## Configuration
- `VGA_SHAPES_MOTION_EN` defined: bounce logic and direction registers are present, and positions move every frame tick.
- `VGA_SHAPES_MOTION_EN` undefined: the direction registers and tick logic are omitted, and positions change only via reset or `iLoad`.
  - Hit test, load, clamp and output timing are identical in both builds.

## Structure
- Package `vga_shapes_pkg` holds:
  - `COLOR_W`=4 and the colour type.
  - The 8-entry palette constant: F00, 0F0, 00F, FF0, 0FF, F0F, FFF, F80.
  - The `SIZE_RST`=60 constant.
- Sub-module `vga_shape_mover`, instantiated once per shape via generate, contains:
  - one shape's x/y/dx/dy registers;
  - the load/clamp logic;
  - the bounce logic under the macro.
- The top level contains the hit test, priority mux, and output/sync registers.

## Test plan
- Reset held, then released with default parameters: first frame shows shape 0 at (0,0) size 60 as F00. Pixel (59,59) is F00; (60,0) is BG; blanking is 0; RGB lags the counters by exactly 1 cycle.
- Overlap: load shapes 0 and 1 both at (100,100) -> pixels inside are F00 (shape 0 priority).
- Right-edge bounce: load x0=578, size=60, STEP=2 -> next tick gives x0=580 with dx=1; the following tick gives x0=580 with dx=0; the one after gives x0=578.
- Left/top bounce: shape 1 at y=1 with dy=0 -> next tick gives y=0 with dy=1.
- Load during tick: pulse `iLoad` with x0=200 in the tick cycle -> x0=200 next frame, not 202.
- Macro off: run 3 frames with no load -> all positions unchanged. Load x0=700 with size=60 -> x0 is clamped to 580.
